// File: rtl/ifu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifu : instruction fetch unit -- PC, credit-limited bus fetch, response FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module ifu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ready_i,
  input  logic        ibus_rsp_valid_i,
  input  logic [31:0] ibus_rsp_data_i,
  input  logic        ibus_rsp_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instruction_o,
  output logic        if_fault_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int SW = CW + 2;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] live_q, live_d, drop_q, drop_d, count_q, count_d;
  logic [AW-1:0] wr_q, rd_q, tag_wr_q, tag_rd_q;

  logic [31:0] tag_q       [BUF_DEPTH];
  logic [31:0] fifo_pc_q   [BUF_DEPTH];
  logic [31:0] fifo_data_q [BUF_DEPTH];
  logic        fifo_err_q  [BUF_DEPTH];

  logic [SW-1:0] w_credit;
  logic          w_accept, w_rsp_live, w_rsp_drop, w_nonempty, w_push, w_pop;

  // Every slot that a live response or a pending drop could claim is reserved up front.
  assign w_credit   = SW'(live_q) + SW'(drop_q) + SW'(count_q);
  assign ibus_req_o = ~rst & ~redirect_i & (w_credit < SW'(BUF_DEPTH));
  assign ibus_addr_o = pc_q;

  assign w_accept   = ibus_req_o & ibus_ready_i;
  assign w_rsp_drop = ibus_rsp_valid_i & (drop_q != '0);
  assign w_rsp_live = ibus_rsp_valid_i & (drop_q == '0);
  assign w_nonempty = (count_q != '0);
  assign w_push     = w_rsp_live & ~redirect_i;
  assign w_pop      = if_valid_o & if_ready_i;

  assign if_valid_o       = w_nonempty & ~redirect_i;
  assign if_pc_o          = fifo_pc_q[rd_q];
  assign if_instruction_o = fifo_data_q[rd_q];
  assign if_fault_o       = w_nonempty & fifo_err_q[rd_q];

  always_comb begin
    pc_d    = pc_q;
    live_d  = live_q;
    drop_d  = drop_q;
    count_d = count_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i & 32'hFFFF_FFFC;
      live_d  = '0;
      drop_d  = drop_q + live_q + CW'(w_accept) - CW'(ibus_rsp_valid_i);
      count_d = '0;
    end else begin
      if (w_accept) pc_d = pc_q + 32'd4;
      live_d  = live_q + CW'(w_accept) - CW'(w_rsp_live);
      drop_d  = drop_q - CW'(w_rsp_drop);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      live_q   <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q    <= pc_d;
      live_q  <= live_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      if (redirect_i) begin
        wr_q     <= '0;
        rd_q     <= '0;
        tag_wr_q <= '0;
        tag_rd_q <= '0;
      end else begin
        if (w_accept) begin
          tag_q[tag_wr_q] <= pc_q;
          tag_wr_q        <= tag_wr_q + AW'(1);
        end
        // Responses return in order, so the oldest tag belongs to this word.
        if (w_push) begin
          fifo_pc_q[wr_q]   <= tag_q[tag_rd_q];
          fifo_data_q[wr_q] <= ibus_rsp_data_i;
          fifo_err_q[wr_q]  <= ibus_rsp_err_i;
          wr_q              <= wr_q + AW'(1);
          tag_rd_q          <= tag_rd_q + AW'(1);
        end
        if (w_pop) rd_q <= rd_q + AW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// tb_ifu : directed, table-driven bench for ifu with an in-order bus model
// and an architectural PC-stream scoreboard on the decode side.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req, ibus_ready, ibus_rsp_valid, ibus_rsp_err;
  logic [31:0] ibus_addr, ibus_rsp_data;
  logic        redirect, if_valid, if_ready, if_fault;
  logic [31:0] redirect_pc, if_pc, if_instruction;

  always #5 clk = ~clk;

  ifu #(.RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ibus_req_o       (ibus_req),
    .ibus_addr_o      (ibus_addr),
    .ibus_ready_i     (ibus_ready),
    .ibus_rsp_valid_i (ibus_rsp_valid),
    .ibus_rsp_data_i  (ibus_rsp_data),
    .ibus_rsp_err_i   (ibus_rsp_err),
    .redirect_i       (redirect),
    .redirect_pc_i    (redirect_pc),
    .if_valid_o       (if_valid),
    .if_ready_i       (if_ready),
    .if_pc_o          (if_pc),
    .if_instruction_o (if_instruction),
    .if_fault_o       (if_fault)
  );

  typedef struct {
    logic        rdr;
    logic [31:0] rpc;
    logic        ifr;
    logic        ren;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] q[$];
  logic [31:0] err_addr = 32'h0000_0001;
  logic [31:0] exp_pc;
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;
  int          faults_seen = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock cycle: present a response (1-cycle latency), drive inputs,
  // log accepts, score decode-side consumption.
  task automatic cycle(input logic rs, input logic rdr, input logic [31:0] rpc,
                       input logic ifr, input logic ibr, input logic ren);
    logic [31:0] a;
    @(posedge clk);
    #1;
    rst            = rs;
    ibus_rsp_valid = 1'b0;
    ibus_rsp_data  = 32'h0;
    ibus_rsp_err   = 1'b0;
    if (rs) q.delete();
    else if (ren && q.size() > 0) begin
      a              = q.pop_front();
      ibus_rsp_valid = 1'b1;
      ibus_rsp_data  = mem(a);
      ibus_rsp_err   = (a == err_addr);
    end
    redirect    = rdr;
    redirect_pc = rpc;
    if_ready    = ifr;
    ibus_ready  = ibr;
    #1;
    if (!rs) begin
      if (ibus_req && ibus_ready) q.push_back(ibus_addr);
      if (rdr) begin
        check("if_valid_during_redirect", {31'b0, if_valid}, 32'h0);
        exp_pc = rpc & 32'hFFFF_FFFC;
      end else if (if_valid && if_ready) begin
        check("stream_pc", if_pc, exp_pc);
        check("stream_instr", if_instruction, mem(exp_pc));
        check("stream_fault", {31'b0, if_fault}, {31'b0, exp_pc == err_addr});
        if (if_fault) faults_seen++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("rst_ibus_req", {31'b0, ibus_req}, 32'h0);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_fault", {31'b0, if_fault}, 32'h0);
    check("rst_ibus_addr", ibus_addr, 32'h0);
    exp_pc      = 32'h0;
    consumed    = 0;
    faults_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ibus_ready = 1'b1; ibus_rsp_valid = 1'b0; ibus_rsp_data = 32'h0;
    ibus_rsp_err = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;

    // rdr rpc ifr ren | ereq eaddr evalid epc
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0});   // C0 first request
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b0, 32'h0});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h8,   1'b1, 32'h0});   // if_pc 0 at T+2
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b1, 32'h4});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b0, 32'h0});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h10,  1'b1, 32'h8});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10,  1'b1, 32'hC});
    tv.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h14,  1'b0, 32'h0});   // C7 decode stalls
    for (int i = 0; i < 9; i++)
      tv.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h18,  1'b1, 32'h10});  // FIFO full, req held 0
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h18,  1'b1, 32'h10});  // release
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h18,  1'b1, 32'h14});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h1C,  1'b0, 32'h0});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h20,  1'b1, 32'h18});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h20,  1'b1, 32'h1C});  // hold responses
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h24,  1'b0, 32'h0});   // 2 in flight
    tv.push_back('{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h28,  1'b0, 32'h0});   // redirect
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0});   // drop 32
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0});   // drop 36
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 32'h100});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h10C, 1'b0, 32'h0});
    tv.push_back('{1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 32'h0});   // redirect + response
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0});   // drop 10C only
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0});
    tv.push_back('{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h208, 1'b1, 32'h200});

    do_reset();
    foreach (tv[i]) begin
      cycle(1'b0, tv[i].rdr, tv[i].rpc, tv[i].ifr, 1'b1, tv[i].ren);
      check($sformatf("vec%0d_req", i), {31'b0, ibus_req}, {31'b0, tv[i].ereq});
      check($sformatf("vec%0d_addr", i), ibus_addr, tv[i].eaddr);
      check($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, tv[i].evalid});
      if (tv[i].evalid) check($sformatf("vec%0d_pc", i), if_pc, tv[i].epc);
    end

    // Access fault on word 8; reset arrives with the FIFO occupied.
    err_addr = 32'h8;
    do_reset();
    run(12);
    check("fault_count", faults_seen, 32'd1);
    check("fault_progress", {31'b0, consumed >= 4}, 32'h1);
    err_addr = 32'h0000_0001;

    // Redirect to the top word, address wrap, stall stability.
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("wrap_req0", {31'b0, ibus_req}, 32'h1);
    check("wrap_addr0", ibus_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("wrap_req1", {31'b0, ibus_req}, 32'h1);
    check("wrap_addr1", ibus_addr, 32'h0000_0000);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check("stall_addr_stable", ibus_addr, 32'h0000_0000);
    run(6);
    check("wrap_progress", {31'b0, consumed >= 3}, 32'h1);

    // Back-to-back redirects with responses outstanding.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
    consumed = 0;
    run(10);
    check("b2b_progress", {31'b0, consumed >= 3}, 32'h1);
    check("b2b_next_pc", exp_pc, 32'h400 + 32'(consumed) * 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
